// File: rtl/pipe_stage_pkg.sv
// Shared pipeline definitions: stage FSM encoding and default widths for
// the IF/ID, ID/EX, EX/MEM and MEM/WB pipe_stage instances.
package pipe_stage_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry (payload + control) with load enable and async reset;
// used for both the main and skid slots of pipe_stage.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] entry_d;
  logic [W-1:0] entry_q;

  always_comb entry_d = load ? d : entry_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_q <= '0;
    else     entry_q <= entry_d;
  end

  assign q = entry_q;

endmodule

// File: rtl/pipe_stage.sv
// Two-entry skid pipeline register with bubble insertion, flush and a
// saturating bubble counter; in_ready depends on registered state only.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int ENTRY_W = DATA_W + CTRL_W;

  state_e              state_q, state_d;
  logic                in_fire, out_fire;
  logic                main_load, skid_load;
  logic [CTRL_W-1:0]   ctrl_in;
  logic [ENTRY_W-1:0]  in_entry, main_d, main_q, skid_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;

  // A bubble keeps its payload but loses every side-effect control bit.
  assign ctrl_in  = in_bubble ? '0 : in_ctrl;
  assign in_entry = {in_data, ctrl_in};
  assign main_d   = (state_q == TWO) ? skid_q : in_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          state_d   = ONE;
          main_load = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && in_bubble && !flush && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  pipe_entry #(.W(ENTRY_W)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

  pipe_entry #(.W(ENTRY_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign out_data   = main_q[ENTRY_W-1:CTRL_W];
  assign out_ctrl   = out_valid ? main_q[CTRL_W-1:0] : '0;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: the driver queues expected entries on
// acceptance, a negedge monitor pops and compares on each output transfer.
module tb_pipe_stage;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          in_bubble = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] bubble_cnt;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          sb[$];
  logic [NW-1:0] exp_cnt = '0;
  int            errors = 0;
  int            checks = 0;

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_bubble  (in_bubble),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop-and-compare per output transfer.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {32'h0, out_data}, 64'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_ctrl", out_ctrl, e.c);
        end
      end else if (!out_valid) begin
        check("ctrl_zero_when_idle", out_ctrl, 0);
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic b);
    bit acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_ctrl   = c;
    in_bubble = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back('{d: d, c: (b ? 8'h00 : c)});
        if (b && exp_cnt != 4'hF) exp_cnt = exp_cnt + 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_bubble = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bubble_cnt", bubble_cnt, 0);
    check("rst_out_data", out_data, 0);
    idle(2);
    rst = 1'b0;

    // Single entry, 1-cycle latency
    out_ready = 1'b1;
    send(32'h1234_56A5, 8'h0F, 1'b0);
    check("lat_out_valid", out_valid, 1);
    check("lat_out_data", out_data, 32'h1234_56A5);
    check("lat_out_ctrl", out_ctrl, 8'h0F);
    check("lat_in_ready", in_ready, 1);
    idle(2);

    // Fill to TWO, hold off C, then drain in order
    out_ready = 1'b0;
    send(32'hAAAA_0001, 8'h11, 1'b0);
    send(32'hBBBB_0002, 8'h22, 1'b0);
    check("two_in_ready", in_ready, 0);
    check("two_out_valid", out_valid, 1);
    in_valid = 1'b1;
    in_data  = 32'hCCCC_0003;
    in_ctrl  = 8'h33;
    idle(2);
    check("holdoff_in_ready", in_ready, 0);
    check("holdoff_head", out_data, 32'hAAAA_0001);
    out_ready = 1'b1;
    send(32'hCCCC_0003, 8'h33, 1'b0);
    idle(3);
    check("order_drained", sb.size(), 0);

    // Bubble clears ctrl, keeps data
    out_ready = 1'b0;
    send(32'hD00D_F00D, 8'hFF, 1'b1);
    check("bub_out_ctrl", out_ctrl, 8'h00);
    check("bub_out_data", out_data, 32'hD00D_F00D);
    check("bub_cnt", bubble_cnt, exp_cnt);
    check("bub_cnt_one", bubble_cnt, 1);
    out_ready = 1'b1;
    idle(2);

    // Back-to-back streaming, ONE with simultaneous transfers
    send(32'h0000_0010, 8'h01, 1'b0);
    send(32'h0000_0020, 8'h02, 1'b0);
    send(32'h0000_0030, 8'h04, 1'b0);
    idle(2);

    // Flush in TWO with a bubble offered: discarded, no count
    out_ready = 1'b0;
    send(32'hEEEE_0005, 8'h55, 1'b0);
    send(32'hFFFF_0006, 8'h66, 1'b0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h6666_0007;
    in_ctrl   = 8'h77;
    in_bubble = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_bubble = 1'b0;
    sb.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_no_count", bubble_cnt, exp_cnt);
    check("flush_data_kept", out_data, 32'hEEEE_0005);
    out_ready = 1'b1;
    idle(3);
    check("flush_stays_empty", out_valid, 0);
    send(32'h1111_0008, 8'h88, 1'b0);
    idle(2);

    // Saturating bubble counter
    for (int i = 0; i < 20 && exp_cnt != 4'hF; i++) send(32'h5A00_0000 + i, 8'hC3, 1'b1);
    check("sat_reach_15", bubble_cnt, 15);
    send(32'h5AFF_FFFF, 8'hC3, 1'b1);
    check("sat_hold_15", bubble_cnt, 15);
    idle(2);

    // Asynchronous reset mid-cycle while in TWO
    out_ready = 1'b0;
    send(32'h9999_0009, 8'h99, 1'b0);
    send(32'hAAAA_000A, 8'hAA, 1'b1);
    check("pre_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_bubble_cnt", bubble_cnt, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_data", out_data, 0);
    sb.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h7777_000B, 8'h3C, 1'b0);
    check("post_rst_out_data", out_data, 32'h7777_000B);
    idle(3);
    check("final_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL take parameter DATA_W, default 128: width of the data payload that passes unchanged (PC, instr, operands, immediate).
REQ-002 The block SHALL take parameter CTRL_W, default 8: width of the side-effect control bits (MemRead, MemWrite, RegWrite, ...) that a bubble clears.
REQ-003 The block SHALL take parameter CNT_W, default 16: width of the bubble counter.
REQ-004 Port clk, input, 1 bit: clock; the block SHALL sample on the rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high; clock clk.
REQ-006 Port flush, input, 1 bit: synchronous kill of all held entries.
REQ-007 Port in_valid, input, 1 bit: upstream entry present.
REQ-008 Port in_ready, output, 1 bit: stage can accept this cycle.
REQ-009 Port in_data, input, DATA_W bits: payload.
REQ-010 Port in_ctrl, input, CTRL_W bits: control bits.
REQ-011 Port in_bubble, input, 1 bit: convert the accepted entry to a bubble.
REQ-012 Port out_valid, output, 1 bit: head entry present.
REQ-013 Port out_ready, input, 1 bit: downstream accepts.
REQ-014 Port out_data, output, DATA_W bits: head payload.
REQ-015 Port out_ctrl, output, CTRL_W bits: head control bits.
REQ-016 Port bubble_cnt, output, CNT_W bits: saturating count of accepted bubbles.

Function
REQ-017 The stage SHALL hold two entries, a main register (head) and a skid register, tracked by a state machine with states EMPTY, ONE and TWO.
REQ-018 in_ready SHALL equal (state != TWO) and SHALL be derived from registered state only, with no combinational path from out_ready.
REQ-019 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-020 out_valid SHALL equal (state != EMPTY), and out_data/out_ctrl SHALL always come from the main register.
REQ-021 Latency SHALL be 1 cycle: an entry accepted in EMPTY SHALL appear on out_* at the next edge.
REQ-022 In ONE, input transfer only -> TWO, with the new entry written to skid.
REQ-023 In ONE, output transfer only -> EMPTY.
REQ-024 In ONE, simultaneous input and output transfers -> ONE, with the new entry written to main.
REQ-025 In TWO, output transfer -> ONE, with skid moved to main; no input transfer is possible in TWO.
REQ-026 In any state with neither transfer, all registers SHALL hold.
REQ-027 Entries SHALL leave in strict acceptance order; none SHALL be lost or duplicated.
REQ-028 Bubble: when an accepted entry has in_bubble=1, its data SHALL be stored unchanged, its ctrl SHALL be stored as all zeros, and bubble_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-029 Flush: on an edge with flush=1, the next state SHALL be EMPTY and any input accepted in that cycle SHALL be discarded, with no bubble_cnt increment.
REQ-030 Flush SHALL leave data registers unchanged; only validity is cleared.
REQ-031 Flush SHALL take priority over every transfer in the same cycle.
REQ-032 out_ctrl SHALL read zero whenever out_valid=0.

Reset
REQ-033 While rst=1, the block SHALL force state EMPTY, all data, ctrl and skid registers to 0, and bubble_cnt to 0.
REQ-034 During reset, out_valid SHALL be 0 and in_ready SHALL be 1.
REQ-035 A reset asserted mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.

Structure
REQ-036 State encodings (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default parameter values SHALL live in the shared pipeline package.
REQ-037 The main and skid entries SHALL be instances of one sub-module, pipe_entry: a DATA_W+CTRL_W register with load enable and async reset.
REQ-038 pipe_stage SHALL replace hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) through parameterisation.

Verification
REQ-039 Reset then in_valid=1, in_data=0x...A5, in_ctrl=0x0F, out_ready=1 -> out_valid=1 with the same data and ctrl after 1 edge; in_ready stays 1.
REQ-040 With out_ready=0, push entries A, B -> state TWO and in_ready=0; C is held off; raising out_ready -> outputs A, B, then C in order.
REQ-041 Accept an entry with in_bubble=1 and in_ctrl=0xFF -> out_ctrl=0x00, out_data unchanged, bubble_cnt=1.
REQ-042 Preload 2^CNT_W-1 bubbles (CNT_W=4: 15), then one more -> bubble_cnt stays 15.
REQ-043 In TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears on out_*.
REQ-044 Assert rst asynchronously mid-cycle while in TWO -> out_valid=0 and bubble_cnt=0 before the next edge.
